// File: rtl/jtag_cfg_pkg.sv
// ---------------------------------------------------------------------------
// jtag_cfg_pkg
// Shared types and widths for the JTAG configuration scheduler.
//   - sched_state_e : scheduler FSM states
//   - JOB_*_W       : default widths of the latched job fields
//   - TMO_CNT_W     : width of the launch/busy timeout counter
//   - TRIES_W       : width of the attempt counter reported with done
// ---------------------------------------------------------------------------
package jtag_cfg_pkg;

  localparam int unsigned JOB_DATA_W   = 256;
  localparam int unsigned JOB_LEN_W    = 8;
  localparam int unsigned JOB_INSTR_W  = 5;
  localparam int unsigned JOB_DEVCNT_W = 5;
  localparam int unsigned TMO_CNT_W    = 32;
  localparam int unsigned TRIES_W      = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT_HI,
    ST_WAIT_LO,
    ST_CHECK,
    ST_REPORT
  } sched_state_e;

endpackage

// File: rtl/jtag_cfg_scheduler_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. The grant goes to the first requesting
// index after last_gnt_i, wrapping cyclically; last_gnt_i itself is checked
// last, so a lone requester is always served.
// Ports:
//   req_i      in  NUM_REQ         request vector
//   last_gnt_i in  $clog2(NUM_REQ) index of the previously served requester
//   gnt_o      out NUM_REQ         one-hot grant (all zero when no request)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] last_gnt_i,
  output logic [NUM_REQ-1:0]         gnt_o
);

  logic [31:0]        cand;
  logic [NUM_REQ-1:0] cand_mask;
  logic               found;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    gnt_o     = '0;
    cand      = '0;
    cand_mask = '0;
    found     = 1'b0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand      = (32'(last_gnt_i) + off) % NUM_REQ;
      cand_mask = NUM_REQ'(1) << cand;
      if (!found && |(req_i & cand_mask)) begin
        gnt_o = cand_mask;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/jtag_cfg_scheduler.sv
// ---------------------------------------------------------------------------
// jtag_cfg_scheduler
// Shares one JTAG master between NUM_REQ configuration requesters. A job is
// granted round-robin, its fields are latched, and it is launched as a TDC or
// ASD action. The scheduler then follows the master's busy flag, samples the
// readback-equality flag and reports a per-job status to the requester.
//
// Optional feature: define JTAG_VERIFY_RETRY_EN to relaunch a job whose
// readback check failed, up to MAX_RETRY extra attempts. Without the macro a
// verify failure is reported immediately and done_tries is always 1.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req / req_is_asd               per-requester request level and job type
//   req_bits/len/inst/devcnt       packed per-requester job fields
//   gnt                            one-hot pulse when a job is latched
//   done, done_ok, done_timeout,   one-hot completion pulse plus status,
//   done_tries                     status held until the next done
//   start_action_tdc/_asd          one-cycle launch pulses to the master
//   jtag_bits, bit_length,         latched job fields, stable launch..done
//   jtag_inst, device_count
//   jtag_busy, tdi_tdo_equal       master busy and readback-equality flags
//   sched_busy                     high whenever the FSM is not idle
// ---------------------------------------------------------------------------
module jtag_cfg_scheduler
  import jtag_cfg_pkg::*;
#(
  parameter int unsigned           NUM_REQ       = 2,
  parameter int unsigned           DATA_W        = JOB_DATA_W,
  parameter int unsigned           INSTR_LENGTH  = JOB_INSTR_W,
  parameter logic [15:0]           START_TIMEOUT = 16'd8192,
  parameter logic [TMO_CNT_W-1:0]  BUSY_TIMEOUT  = 32'd2_000_000,
  parameter int unsigned           MAX_RETRY     = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_is_asd,
  input  logic [NUM_REQ*DATA_W-1:0]        req_bits,
  input  logic [NUM_REQ*JOB_LEN_W-1:0]     req_len,
  input  logic [NUM_REQ*INSTR_LENGTH-1:0]  req_inst,
  input  logic [NUM_REQ*JOB_DEVCNT_W-1:0]  req_devcnt,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               done,
  output logic                             done_ok,
  output logic                             done_timeout,
  output logic [TRIES_W-1:0]               done_tries,
  output logic                             start_action_tdc,
  output logic                             start_action_asd,
  output logic [DATA_W-1:0]                jtag_bits,
  output logic [JOB_LEN_W-1:0]             bit_length,
  output logic [INSTR_LENGTH-1:0]          jtag_inst,
  output logic [JOB_DEVCNT_W-1:0]          device_count,
  input  logic                             jtag_busy,
  input  logic                             tdi_tdo_equal,
  output logic                             sched_busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

`ifdef JTAG_VERIFY_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  // Arbitration and selection of the winning requester's fields
  logic [NUM_REQ-1:0]      arb_gnt;
  logic [IDX_W-1:0]        sel_idx;
  logic                    sel_asd;
  logic [DATA_W-1:0]       sel_bits;
  logic [JOB_LEN_W-1:0]    sel_len;
  logic [INSTR_LENGTH-1:0] sel_inst;
  logic [JOB_DEVCNT_W-1:0] sel_devcnt;

  // FSM state and registered outputs
  sched_state_e            state_q;
  logic [IDX_W-1:0]        idx_q;
  logic [IDX_W-1:0]        last_gnt_q;
  logic [NUM_REQ-1:0]      idx_oh_q;
  logic                    is_asd_q;
  logic [TRIES_W-1:0]      tries_q;
  logic                    ok_q;
  logic                    timeout_q;
  logic [TMO_CNT_W-1:0]    cnt_q;
  logic [NUM_REQ-1:0]      gnt_q;
  logic [NUM_REQ-1:0]      done_q;
  logic                    done_ok_q;
  logic                    done_timeout_q;
  logic [TRIES_W-1:0]      done_tries_q;
  logic                    start_tdc_q;
  logic                    start_asd_q;
  logic [DATA_W-1:0]       bits_q;
  logic [JOB_LEN_W-1:0]    len_q;
  logic [INSTR_LENGTH-1:0] inst_q;
  logic [JOB_DEVCNT_W-1:0] devcnt_q;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr_arbiter (
    .req_i      (req),
    .last_gnt_i (last_gnt_q),
    .gnt_o      (arb_gnt)
  );

  always_comb begin
    sel_idx    = '0;
    sel_asd    = 1'b0;
    sel_bits   = '0;
    sel_len    = '0;
    sel_inst   = '0;
    sel_devcnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) begin
        sel_idx    = IDX_W'(i);
        sel_asd    = req_is_asd[i];
        sel_bits   = req_bits[i*DATA_W +: DATA_W];
        sel_len    = req_len[i*JOB_LEN_W +: JOB_LEN_W];
        sel_inst   = req_inst[i*INSTR_LENGTH +: INSTR_LENGTH];
        sel_devcnt = req_devcnt[i*JOB_DEVCNT_W +: JOB_DEVCNT_W];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      last_gnt_q     <= IDX_W'(NUM_REQ - 1);
      idx_oh_q       <= '0;
      is_asd_q       <= 1'b0;
      tries_q        <= '0;
      ok_q           <= 1'b0;
      timeout_q      <= 1'b0;
      cnt_q          <= '0;
      gnt_q          <= '0;
      done_q         <= '0;
      done_ok_q      <= 1'b0;
      done_timeout_q <= 1'b0;
      done_tries_q   <= '0;
      start_tdc_q    <= 1'b0;
      start_asd_q    <= 1'b0;
      bits_q         <= '0;
      len_q          <= '0;
      inst_q         <= '0;
      devcnt_q       <= '0;
    end else begin
      // Pulse outputs fall back to zero unless a state raises them
      gnt_q       <= '0;
      done_q      <= '0;
      start_tdc_q <= 1'b0;
      start_asd_q <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (|req) begin
            gnt_q     <= arb_gnt;
            idx_q     <= sel_idx;
            idx_oh_q  <= arb_gnt;
            is_asd_q  <= sel_asd;
            bits_q    <= sel_bits;
            len_q     <= sel_len;
            inst_q    <= sel_inst;
            devcnt_q  <= sel_devcnt;
            tries_q   <= TRIES_W'(1);
            ok_q      <= 1'b0;
            timeout_q <= 1'b0;
            state_q   <= ST_LAUNCH;
          end
        end

        ST_LAUNCH: begin
          start_asd_q <= is_asd_q;
          start_tdc_q <= !is_asd_q;
          cnt_q       <= '0;
          state_q     <= ST_WAIT_HI;
        end

        ST_WAIT_HI: begin
          if (jtag_busy) begin
            cnt_q   <= '0;
            state_q <= ST_WAIT_LO;
          end else if (cnt_q >= TMO_CNT_W'(START_TIMEOUT)) begin
            timeout_q <= 1'b1;
            state_q   <= ST_REPORT;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_WAIT_LO: begin
          if (!jtag_busy) begin
            state_q <= ST_CHECK;
          end else if (cnt_q >= BUSY_TIMEOUT) begin
            timeout_q <= 1'b1;
            state_q   <= ST_REPORT;
          end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        ST_CHECK: begin
          ok_q <= tdi_tdo_equal;
          // Relaunch the same latched job while retry budget remains
          if (RETRY_EN && !tdi_tdo_equal && (32'(tries_q) <= 32'(MAX_RETRY))) begin
            tries_q <= tries_q + 1'b1;
            state_q <= ST_LAUNCH;
          end else begin
            state_q <= ST_REPORT;
          end
        end

        ST_REPORT: begin
          done_q         <= idx_oh_q;
          done_ok_q      <= ok_q;
          done_timeout_q <= timeout_q;
          done_tries_q   <= tries_q;
          last_gnt_q     <= idx_q;
          state_q        <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gnt              = gnt_q;
  assign done             = done_q;
  assign done_ok          = done_ok_q;
  assign done_timeout     = done_timeout_q;
  assign done_tries       = done_tries_q;
  assign start_action_tdc = start_tdc_q;
  assign start_action_asd = start_asd_q;
  assign jtag_bits        = bits_q;
  assign bit_length       = len_q;
  assign jtag_inst        = inst_q;
  assign device_count     = devcnt_q;
  assign sched_busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_jtag_cfg_scheduler.sv
// ---------------------------------------------------------------------------
// tb_jtag_cfg_scheduler
// Scoreboard bench for jtag_cfg_scheduler. Each job's expected grant and
// completion status are queued when its request is driven; a monitor pops
// and compares them when gnt/done pulse. A small master model answers the
// start pulses with a configurable busy window and readback-equality flag.
// BUSY_TIMEOUT is overridden to 1000 cycles to keep the run short.
// ---------------------------------------------------------------------------
module tb_jtag_cfg_scheduler;

  localparam int NUM_REQ      = 2;
  localparam int DATA_W       = 256;
  localparam int INSTR_LENGTH = 5;

  logic                            clk = 1'b0;
  logic                            rst;
  logic [NUM_REQ-1:0]              req;
  logic [NUM_REQ-1:0]              req_is_asd;
  logic [NUM_REQ*DATA_W-1:0]       req_bits;
  logic [NUM_REQ*8-1:0]            req_len;
  logic [NUM_REQ*INSTR_LENGTH-1:0] req_inst;
  logic [NUM_REQ*5-1:0]            req_devcnt;
  logic [NUM_REQ-1:0]              gnt;
  logic [NUM_REQ-1:0]              done;
  logic                            done_ok;
  logic                            done_timeout;
  logic [2:0]                      done_tries;
  logic                            start_action_tdc;
  logic                            start_action_asd;
  logic [DATA_W-1:0]               jtag_bits;
  logic [7:0]                      bit_length;
  logic [INSTR_LENGTH-1:0]         jtag_inst;
  logic [4:0]                      device_count;
  logic                            jtag_busy;
  logic                            tdi_tdo_equal;
  logic                            sched_busy;

  always #5 clk = ~clk;

  jtag_cfg_scheduler #(
    .NUM_REQ      (NUM_REQ),
    .DATA_W       (DATA_W),
    .INSTR_LENGTH (INSTR_LENGTH),
    .BUSY_TIMEOUT (32'd1000)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req              (req),
    .req_is_asd       (req_is_asd),
    .req_bits         (req_bits),
    .req_len          (req_len),
    .req_inst         (req_inst),
    .req_devcnt       (req_devcnt),
    .gnt              (gnt),
    .done             (done),
    .done_ok          (done_ok),
    .done_timeout     (done_timeout),
    .done_tries       (done_tries),
    .start_action_tdc (start_action_tdc),
    .start_action_asd (start_action_asd),
    .jtag_bits        (jtag_bits),
    .bit_length       (bit_length),
    .jtag_inst        (jtag_inst),
    .device_count     (device_count),
    .jtag_busy        (jtag_busy),
    .tdi_tdo_equal    (tdi_tdo_equal),
    .sched_busy       (sched_busy)
  );

  typedef struct {
    int                      idx;
    logic                    is_asd;
    logic                    ok;
    logic                    tmo;
    logic [2:0]              tries;
    logic [DATA_W-1:0]       bits;
    logic [7:0]              len;
    logic [INSTR_LENGTH-1:0] inst;
    logic [4:0]              dev;
  } job_t;

  job_t done_exp[$];
  int   gnt_exp[$];
  logic eq_q[$];

  int n_cmp    = 0;
  int n_bad    = 0;
  int n_starts = 0;
  int n_dones  = 0;
  int busy_len = 20;
  bit busy_never = 1'b0;
  bit kill_busy  = 1'b0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Master model: answers each launch pulse with a busy window, then
  // presents the next queued equality result (1 when the queue is empty).
  initial begin
    jtag_busy     = 1'b0;
    tdi_tdo_equal = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && (start_action_tdc || start_action_asd)) begin
        n_starts++;
        if (!busy_never) begin
          repeat (2) @(negedge clk);
          jtag_busy     = 1'b1;
          tdi_tdo_equal = 1'b0;
          for (int c = 0; c < busy_len && !kill_busy; c++) @(negedge clk);
          tdi_tdo_equal = (eq_q.size() > 0) ? eq_q.pop_front() : 1'b1;
          jtag_busy     = 1'b0;
        end
      end
    end
  end

  // Monitor: checks launch pulses and pops the scoreboard on gnt/done.
  initial begin : monitor
    job_t e;
    logic prev_start;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (start_action_tdc || start_action_asd) begin
          check("start_excl", 256'(start_action_tdc & start_action_asd), 256'(0));
          check("start_width", 256'(prev_start), 256'(0));
          if (done_exp.size() > 0)
            check("start_type", 256'(start_action_asd), 256'(done_exp[0].is_asd));
          else
            check("start_unexpected", 256'(1), 256'(0));
        end
        if (|gnt) begin
          if (gnt_exp.size() > 0)
            check("gnt", 256'(gnt), 256'(1) << gnt_exp.pop_front());
          else
            check("gnt_unexpected", 256'(gnt), 256'(0));
        end
        if (|done) begin
          n_dones++;
          if (done_exp.size() > 0) begin
            e = done_exp.pop_front();
            check("done_vec",     256'(done), 256'(1) << e.idx);
            check("done_ok",      256'(done_ok), 256'(e.ok));
            check("done_timeout", 256'(done_timeout), 256'(e.tmo));
            check("done_tries",   256'(done_tries), 256'(e.tries));
            check("jtag_bits",    jtag_bits, e.bits);
            check("bit_length",   256'(bit_length), 256'(e.len));
            check("jtag_inst",    256'(jtag_inst), 256'(e.inst));
            check("device_count", 256'(device_count), 256'(e.dev));
          end else begin
            check("done_unexpected", 256'(done), 256'(0));
          end
        end
      end
      prev_start = start_action_tdc | start_action_asd;
    end
  end

  // Present a fresh random job on requester i and queue its expectations.
  task automatic load_job(input int i, input logic asd, input logic ok,
                          input logic tmo, input logic [2:0] tries);
    job_t j;
    j.idx    = i;
    j.is_asd = asd;
    j.ok     = ok;
    j.tmo    = tmo;
    j.tries  = tries;
    for (int w = 0; w < DATA_W / 32; w++) j.bits[w*32 +: 32] = $urandom();
    j.len  = 8'($urandom());
    j.inst = INSTR_LENGTH'($urandom());
    j.dev  = 5'($urandom());
    req_is_asd[i] = asd;
    req_bits[i*DATA_W +: DATA_W]             = j.bits;
    req_len[i*8 +: 8]                        = j.len;
    req_inst[i*INSTR_LENGTH +: INSTR_LENGTH] = j.inst;
    req_devcnt[i*5 +: 5]                     = j.dev;
    done_exp.push_back(j);
    gnt_exp.push_back(i);
  endtask

  // Raise the requests in m and drop each one when its grant is seen.
  task automatic grant_all(input logic [NUM_REQ-1:0] m, input int budget);
    req = req | m;
    while (req != '0 && budget > 0) begin
      @(negedge clk);
      req = req & ~gnt;
      budget--;
    end
    if (req != '0) begin
      check("grant_wait", 256'(req), 256'(0));
      req = '0;
    end
  endtask

  // Wait until all queued jobs have completed and the master is idle.
  task automatic drain(input int budget);
    while ((done_exp.size() > 0 || gnt_exp.size() > 0 || sched_busy || jtag_busy)
           && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (done_exp.size() > 0 || gnt_exp.size() > 0 || sched_busy || jtag_busy) begin
      check("drain_wait", 256'(1), 256'(0));
      done_exp.delete();
      gnt_exp.delete();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_gnt"},    256'(gnt), 256'(0));
    check({tag, "_done"},   256'({done, done_ok, done_timeout, done_tries}), 256'(0));
    check({tag, "_start"},  256'({start_action_tdc, start_action_asd}), 256'(0));
    check({tag, "_bits"},   jtag_bits, 256'(0));
    check({tag, "_fields"}, 256'({bit_length, jtag_inst, device_count}), 256'(0));
    check({tag, "_busy"},   256'(sched_busy), 256'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    int d0;
    int w;
    rst        = 1'b1;
    req        = '0;
    req_is_asd = '0;
    req_bits   = '0;
    req_len    = '0;
    req_inst   = '0;
    req_devcnt = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Contention after reset: last_gnt = NUM_REQ-1, so index 0 wins first.
    busy_len = 20;
    load_job(0, 1'b0, 1'b1, 1'b0, 3'd1);
    load_job(1, 1'b1, 1'b1, 1'b0, 3'd1);
    grant_all(2'b11, 2000);
    drain(2000);

    // Next contention: last_gnt is 1 again, index 0 wins again.
    load_job(0, 1'b1, 1'b1, 1'b0, 3'd1);
    load_job(1, 1'b0, 1'b1, 1'b0, 3'd1);
    grant_all(2'b11, 2000);
    drain(2000);
    repeat (5) @(negedge clk);
    check("done_hold_ok", 256'(done_ok), 256'(1));
    check("done_hold_tries", 256'(done_tries), 256'(1));

    // Single TDC job, busy high for 500 cycles, readback equal.
    busy_len = 500;
    s0 = n_starts;
    load_job(0, 1'b0, 1'b1, 1'b0, 3'd1);
    grant_all(2'b01, 50);
    drain(2000);
    check("tdc_starts", 256'(n_starts - s0), 256'(1));

    // Verify failure on the first two attempts, then success.
    busy_len = 30;
    eq_q.push_back(1'b0);
    eq_q.push_back(1'b0);
    eq_q.push_back(1'b1);
    s0 = n_starts;
`ifdef JTAG_VERIFY_RETRY_EN
    load_job(1, 1'b1, 1'b1, 1'b0, 3'd3);
`else
    load_job(1, 1'b1, 1'b0, 1'b0, 3'd1);
`endif
    grant_all(2'b10, 50);
    drain(5000);
`ifdef JTAG_VERIFY_RETRY_EN
    check("retry_starts", 256'(n_starts - s0), 256'(3));
`else
    check("retry_starts", 256'(n_starts - s0), 256'(1));
`endif
    eq_q.delete();

    // ASD job whose busy never rises: start timeout, no retry.
    busy_never = 1'b1;
    s0 = n_starts;
    load_job(0, 1'b1, 1'b0, 1'b1, 3'd1);
    grant_all(2'b01, 50);
    drain(9000);
    busy_never = 1'b0;
    check("start_tmo_starts", 256'(n_starts - s0), 256'(1));

    // Busy held past BUSY_TIMEOUT; the requester changes its payload and
    // drops req after the grant, the latched fields must not follow.
    busy_len = 1500;
    s0 = n_starts;
    load_job(1, 1'b0, 1'b0, 1'b1, 3'd1);
    grant_all(2'b10, 50);
    req_bits   = ~req_bits;
    req_len    = ~req_len;
    req_inst   = ~req_inst;
    req_devcnt = ~req_devcnt;
    drain(3000);
    check("busy_tmo_starts", 256'(n_starts - s0), 256'(1));

    // Reset while the FSM waits for busy to fall: job abandoned, no done.
    busy_len = 300;
    load_job(0, 1'b0, 1'b1, 1'b0, 3'd1);
    grant_all(2'b01, 50);
    w = 0;
    while (!jtag_busy && w < 100) begin
      @(negedge clk);
      w++;
    end
    check("rst_busy_seen", 256'(jtag_busy), 256'(1));
    repeat (10) @(negedge clk);
    d0 = n_dones;
    rst = 1'b1;
    kill_busy = 1'b1;
    @(negedge clk);
    check_reset_outputs("midjob_rst");
    repeat (2) @(negedge clk);
    done_exp.delete();
    gnt_exp.delete();
    kill_busy = 1'b0;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_no_done", 256'(n_dones - d0), 256'(0));

    // Normal operation after reset: last_gnt is back to NUM_REQ-1.
    busy_len = 20;
    load_job(0, 1'b0, 1'b1, 1'b0, 3'd1);
    load_job(1, 1'b1, 1'b1, 1'b0, 3'd1);
    grant_all(2'b11, 2000);
    drain(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
